dest_zone_ctrl: RTL and testbench
=================================

DEST_ZONE_CTRL -- requirements
Module: dest_zone_ctrl

Interface
REQ-001 SHALL have parameter NUM_ZONES, default 4: number of destination zones, 1..16.
REQ-002 SHALL have parameter POS_W, default 12: position/size width in pixels.
REQ-003 SHALL have parameter DWELL, default 4: consecutive frame_tick hits to capture a zone, 1..255.
REQ-004 SHALL have parameter ORDERED, default 0: 1 = zones must be captured in ascending index order.
REQ-005 SHALL have one clock and a synchronous, active-high reset, named clk and rst; all state SHALL change only on rising clk.
REQ-006 SHALL have port clk, input, 1 bit: system clock.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port level_start, input, 1 bit: one-cycle pulse that arms a new level.
REQ-009 SHALL have port frame_tick, input, 1 bit: one-cycle pulse per video frame; the evaluation strobe.
REQ-010 SHALL have ports player_hPos and player_vPos, inputs, POS_W bits each: player position.
REQ-011 SHALL have ports zone_hStart, zone_vStart, zone_width and zone_height, inputs, NUM_ZONES*POS_W bits each, zone i at slice [i*POS_W +: POS_W].
REQ-012 SHALL have port zone_en, input, NUM_ZONES bits: per-zone enable, sampled on level_start.
REQ-013 SHALL have port captured, output, NUM_ZONES bits: per-zone capture flags.
REQ-014 SHALL have port zone_visible, output, NUM_ZONES bits: equal to en_q & ~captured when state is ARMED, else 0.
REQ-015 SHALL have port current_zone, output, $clog2(NUM_ZONES) bits (minimum 1): lowest-index enabled uncaptured zone; 0 if none.
REQ-016 SHALL have port capture_count, output, $clog2(NUM_ZONES+1) bits: popcount of captured.
REQ-017 SHALL have port level_complete, output, 1 bit: held high in state COMPLETE.
REQ-018 SHALL have port complete_pulse, output, 1 bit: high for exactly one cycle on entry to COMPLETE.

Function
REQ-019 SHALL implement FSM states IDLE, ARMED and COMPLETE.
REQ-020 SHALL, on level_start in any state, latch zone_en into en_q, clear captured and all dwell counters, and enter ARMED on the next cycle.
REQ-021 SHALL give level_start priority over a frame_tick in the same cycle; that frame_tick is ignored.
REQ-022 SHALL compute zone i hit as hStart <= hPos < hStart+width AND vStart <= vPos < vStart+height, with sums computed at POS_W+1 bits (no wrap).
REQ-023 SHALL never report a hit for a zone with width 0 or height 0.
REQ-024 SHALL treat zone i as eligible when en_q[i]=1, captured[i]=0, and, if ORDERED=1, i == current_zone.
REQ-025 SHALL, in ARMED on frame_tick, increment an eligible zone's dwell counter when the zone is hit, and clear it when not hit.
REQ-026 SHALL, in ARMED on frame_tick, set captured[i] on the DWELL-th consecutive hit, visible in the cycle after the tick, and clear that counter.
REQ-027 SHALL hold dwell counters and captured unchanged on cycles without frame_tick.
REQ-028 SHALL, with ORDERED=0, let multiple zones capture on the same tick independently.
REQ-029 SHALL, with ORDERED=1, never advance a non-eligible zone's counter even when it is hit.
REQ-030 SHALL move ARMED to COMPLETE on the cycle after captured covers en_q, asserting level_complete and complete_pulse in that cycle (frame_tick at cycle T -> captured at T+1 -> level_complete at T+2).
REQ-031 SHALL, if en_q is 0, enter COMPLETE on the first frame_tick in ARMED.
REQ-032 SHALL ignore frame_tick in IDLE and COMPLETE; COMPLETE SHALL persist until level_start or rst.
REQ-033 SHALL abandon a level in progress on level_start with no completion pulse.

Reset
REQ-034 SHALL, on rst=1, enter IDLE and clear en_q, captured, dwell counters, level_complete and complete_pulse, giving current_zone=0, capture_count=0 and zone_visible=0.
REQ-035 SHALL give rst priority over level_start and frame_tick, and SHALL act on the first rising clk with rst high, including mid-dwell and in COMPLETE.

Verification
REQ-036 SHALL cover basic dwell: defaults, zone0 at (100,50) size 16x16, zone_en=4'b0001, player at (108,55) for 4 ticks -> captured=0001 the cycle after the 4th tick, level_complete the next cycle, complete_pulse one cycle wide.
REQ-037 SHALL cover edge exclusion: player at (116,55) (hStart+width) -> no hit; player at (100,50) -> hit.
REQ-038 SHALL cover dwell break: hits on ticks 1-3, miss on tick 4, hits on ticks 5-8 -> captured[0] set only after tick 8.
REQ-039 SHALL cover ordered mode: ORDERED=1, zone_en=0011, player dwells 4 ticks in zone1 then 4 in zone0 -> only zone0 captured, current_zone=1; zone1 needs 4 further ticks.
REQ-040 SHALL cover simultaneous capture: ORDERED=0, zones 0 and 1 overlapping, player in both for 4 ticks -> captured=0011 on the same cycle, capture_count=2, level_complete at T+2.
REQ-041 SHALL cover rst and restart: rst mid-dwell (counter 3) -> IDLE, all outputs 0; level_start with frame_tick in the same cycle -> ARMED, counters 0, tick ignored.

Source files
------------

// File: rtl/dest_zone_ctrl.sv
// Destination zone controller: per-frame dwell counting of the player inside up to 16 rectangles.
// Latency: capture is registered the cycle after the frame_tick; level_complete follows one cycle later.
// Backpressure: none; frame_tick is a strobe and inputs are sampled every cycle.
//
// Ports:
//   clk, rst                  clock and synchronous active-high reset
//   level_start               pulse: latch zone_en, clear progress, arm the level
//   frame_tick                pulse: per-frame evaluation strobe
//   player_hPos/vPos          player position
//   zone_hStart/vStart/width/height  packed per-zone geometry, zone i at [i*POS_W +: POS_W]
//   zone_en                   per-zone enable, sampled on level_start
//   captured, zone_visible, current_zone, capture_count, level_complete, complete_pulse  status
module dest_zone_ctrl #(
    parameter int NUM_ZONES = 4,
    parameter int POS_W     = 12,
    parameter int DWELL     = 4,
    parameter int ORDERED   = 0,
    localparam int CZ_W     = (NUM_ZONES > 1) ? $clog2(NUM_ZONES) : 1,
    localparam int CNT_W    = $clog2(NUM_ZONES + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       level_start,
    input  logic                       frame_tick,
    input  logic [POS_W-1:0]           player_hPos,
    input  logic [POS_W-1:0]           player_vPos,
    input  logic [NUM_ZONES*POS_W-1:0] zone_hStart,
    input  logic [NUM_ZONES*POS_W-1:0] zone_vStart,
    input  logic [NUM_ZONES*POS_W-1:0] zone_width,
    input  logic [NUM_ZONES*POS_W-1:0] zone_height,
    input  logic [NUM_ZONES-1:0]       zone_en,
    output logic [NUM_ZONES-1:0]       captured,
    output logic [NUM_ZONES-1:0]       zone_visible,
    output logic [CZ_W-1:0]            current_zone,
    output logic [CNT_W-1:0]           capture_count,
    output logic                       level_complete,
    output logic                       complete_pulse
);

    localparam int DW_W = $clog2(DWELL + 1);
    localparam logic [DW_W-1:0] DWELL_LAST = DW_W'(DWELL - 1);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_ARMED    = 2'd1;
    localparam logic [1:0] S_COMPLETE = 2'd2;

    logic [1:0]           r_state;
    logic [NUM_ZONES-1:0] r_en_q;
    logic [NUM_ZONES-1:0] r_captured;
    logic                 r_pulse;
    logic [DW_W-1:0]      r_dwell [NUM_ZONES];

    logic [NUM_ZONES-1:0] w_hit;
    logic [NUM_ZONES-1:0] w_elig;
    logic [CZ_W-1:0]      w_cur;
    logic [CNT_W-1:0]     w_cnt;
    logic                 w_all_done;
    logic                 w_to_complete;

    // Lowest-index enabled zone not yet captured; 0 when none remain.
    always_comb begin
        w_cur = '0;
        for (int i = NUM_ZONES - 1; i >= 0; i--) begin
            if (r_en_q[i] && !r_captured[i]) begin
                w_cur = CZ_W'(i);
            end
        end
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_ZONES; i++) begin
            w_cnt = w_cnt + CNT_W'(r_captured[i]);
        end
    end

    // Bounds are widened by one bit so hStart+width cannot wrap. The upper
    // bound is exclusive, so a zero width or height never produces a hit.
    for (genvar gi = 0; gi < NUM_ZONES; gi++) begin : g_zone
        logic [POS_W:0] w_h_lo, w_h_hi, w_v_lo, w_v_hi, w_h, w_v;
        assign w_h    = {1'b0, player_hPos};
        assign w_v    = {1'b0, player_vPos};
        assign w_h_lo = {1'b0, zone_hStart[gi*POS_W +: POS_W]};
        assign w_v_lo = {1'b0, zone_vStart[gi*POS_W +: POS_W]};
        assign w_h_hi = w_h_lo + {1'b0, zone_width[gi*POS_W +: POS_W]};
        assign w_v_hi = w_v_lo + {1'b0, zone_height[gi*POS_W +: POS_W]};
        assign w_hit[gi] = (w_h >= w_h_lo) && (w_h < w_h_hi) &&
                           (w_v >= w_v_lo) && (w_v < w_v_hi);
        assign w_elig[gi] = r_en_q[gi] && !r_captured[gi] &&
                            ((ORDERED == 0) || (w_cur == CZ_W'(gi)));
    end

    assign w_all_done = ((r_captured & r_en_q) == r_en_q);

    // An empty enable set would be "covered" immediately, so it instead
    // completes on the first frame evaluated in ARMED. Otherwise completion
    // follows the cycle in which the registered captures cover en_q.
    assign w_to_complete = (r_en_q == '0) ? frame_tick : w_all_done;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_en_q     <= '0;
            r_captured <= '0;
            r_pulse    <= 1'b0;
            for (int i = 0; i < NUM_ZONES; i++) begin
                r_dwell[i] <= '0;
            end
        end else begin
            r_pulse <= 1'b0;
            if (level_start) begin
                // Also abandons any level in progress; a coincident frame_tick is dropped.
                r_state    <= S_ARMED;
                r_en_q     <= zone_en;
                r_captured <= '0;
                for (int i = 0; i < NUM_ZONES; i++) begin
                    r_dwell[i] <= '0;
                end
            end else if (r_state == S_ARMED) begin
                if (frame_tick) begin
                    for (int i = 0; i < NUM_ZONES; i++) begin
                        if (w_elig[i]) begin
                            if (!w_hit[i]) begin
                                r_dwell[i] <= '0;
                            end else if (r_dwell[i] == DWELL_LAST) begin
                                r_captured[i] <= 1'b1;
                                r_dwell[i]    <= '0;
                            end else begin
                                r_dwell[i] <= r_dwell[i] + DW_W'(1);
                            end
                        end
                    end
                end
                if (w_to_complete) begin
                    r_state <= S_COMPLETE;
                    r_pulse <= 1'b1;
                end
            end
        end
    end

    assign captured       = r_captured;
    assign zone_visible   = (r_state == S_ARMED) ? (r_en_q & ~r_captured) : '0;
    assign current_zone   = w_cur;
    assign capture_count  = w_cnt;
    assign level_complete = (r_state == S_COMPLETE);
    assign complete_pulse = r_pulse;

endmodule

// File: tb/tb_dest_zone_ctrl.sv
// Bench for dest_zone_ctrl: one unordered and one ordered instance share stimulus.
// Latency: outputs are compared 1 time unit after each rising edge.
// Backpressure: not applicable.
module tb_dest_zone_ctrl;

    logic        clk = 1'b0;
    logic        rst, level_start, frame_tick;
    logic [11:0] player_hPos, player_vPos;
    logic [47:0] zone_hStart, zone_vStart, zone_width, zone_height;
    logic [3:0]  zone_en;

    logic [3:0] cap0, vis0, cap1, vis1;
    logic [1:0] cur0, cur1;
    logic [2:0] cnt0, cnt1;
    logic       lc0, pl0, lc1, pl1;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dest_zone_ctrl #(.NUM_ZONES(4), .POS_W(12), .DWELL(4), .ORDERED(0)) dut0 (
        .clk(clk), .rst(rst), .level_start(level_start), .frame_tick(frame_tick),
        .player_hPos(player_hPos), .player_vPos(player_vPos),
        .zone_hStart(zone_hStart), .zone_vStart(zone_vStart),
        .zone_width(zone_width), .zone_height(zone_height), .zone_en(zone_en),
        .captured(cap0), .zone_visible(vis0), .current_zone(cur0),
        .capture_count(cnt0), .level_complete(lc0), .complete_pulse(pl0));

    dest_zone_ctrl #(.NUM_ZONES(4), .POS_W(12), .DWELL(4), .ORDERED(1)) dut1 (
        .clk(clk), .rst(rst), .level_start(level_start), .frame_tick(frame_tick),
        .player_hPos(player_hPos), .player_vPos(player_vPos),
        .zone_hStart(zone_hStart), .zone_vStart(zone_vStart),
        .zone_width(zone_width), .zone_height(zone_height), .zone_en(zone_en),
        .captured(cap1), .zone_visible(vis1), .current_zone(cur1),
        .capture_count(cnt1), .level_complete(lc1), .complete_pulse(pl1));

    // Zone geometry: zone1 overlaps zone0; zone2 has zero width.
    int zh[4] = '{100, 104, 300, 400};
    int zv[4] = '{50,  52,  300, 400};
    int zw[4] = '{16,  16,  0,   8};
    int zt[4] = '{16,  16,  10,  8};

    // Reference model: phase 0=idle 1=armed 2=complete, per-zone consecutive-hit tallies.
    int       m_phase[2];
    bit [3:0] m_en[2];
    bit [3:0] m_cap[2];
    int       m_dw[2][4];
    bit       m_pulse[2];

    function automatic bit inside_zone(int z, int h, int v);
        return (h >= zh[z]) && (h < zh[z] + zw[z]) && (v >= zv[z]) && (v < zv[z] + zt[z]);
    endfunction

    function automatic int first_open(bit [3:0] en, bit [3:0] cp);
        for (int i = 0; i < 4; i++) if (en[i] && !cp[i]) return i;
        return 0;
    endfunction

    task automatic model_step(int k, bit ordered);
        bit finish_now;
        int target;
        if (rst) begin
            m_phase[k] = 0; m_en[k] = 0; m_cap[k] = 0; m_pulse[k] = 0;
            for (int z = 0; z < 4; z++) m_dw[k][z] = 0;
        end else if (level_start) begin
            m_phase[k] = 1; m_en[k] = zone_en; m_cap[k] = 0; m_pulse[k] = 0;
            for (int z = 0; z < 4; z++) m_dw[k][z] = 0;
        end else begin
            m_pulse[k] = 0;
            if (m_phase[k] == 1) begin
                if (m_en[k] == 0) finish_now = frame_tick;
                else finish_now = ((m_cap[k] & m_en[k]) == m_en[k]);
                if (frame_tick) begin
                    target = first_open(m_en[k], m_cap[k]);
                    for (int z = 0; z < 4; z++) begin
                        if (m_en[k][z] && !m_cap[k][z] && (!ordered || z == target)) begin
                            if (inside_zone(z, int'(player_hPos), int'(player_vPos))) begin
                                m_dw[k][z]++;
                                if (m_dw[k][z] == 4) begin
                                    m_cap[k][z] = 1'b1;
                                    m_dw[k][z]  = 0;
                                end
                            end else begin
                                m_dw[k][z] = 0;
                            end
                        end
                    end
                end
                if (finish_now) begin
                    m_phase[k] = 2;
                    m_pulse[k] = 1'b1;
                end
            end
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model(int k, logic [3:0] cp, logic [3:0] vs, logic [1:0] cu,
                               logic [2:0] cn, logic lc, logic pl);
        bit [3:0] ev;
        ev = (m_phase[k] == 1) ? (m_en[k] & ~m_cap[k]) : 4'b0;
        chk($sformatf("dut%0d captured", k), 32'(cp), 32'(m_cap[k]));
        chk($sformatf("dut%0d zone_visible", k), 32'(vs), 32'(ev));
        chk($sformatf("dut%0d current_zone", k), 32'(cu), 32'(first_open(m_en[k], m_cap[k])));
        chk($sformatf("dut%0d capture_count", k), 32'(cn), 32'($countones(m_cap[k])));
        chk($sformatf("dut%0d level_complete", k), 32'(lc), 32'(m_phase[k] == 2));
        chk($sformatf("dut%0d complete_pulse", k), 32'(pl), 32'(m_pulse[k]));
    endtask

    task automatic cycle();
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        @(posedge clk);
        #1;
        check_model(0, cap0, vis0, cur0, cnt0, lc0, pl0);
        check_model(1, cap1, vis1, cur1, cnt1, lc1, pl1);
    endtask

    task automatic drive(bit r, bit ls, bit ft, int h, int v, bit [3:0] en);
        rst = r; level_start = ls; frame_tick = ft;
        player_hPos = 12'(h); player_vPos = 12'(v); zone_en = en;
    endtask

    typedef struct {
        bit       r, ls, ft;
        int       h, v;
        bit [3:0] en;
        bit [3:0] ecap;
        int       ecnt;
        bit       elc, epl;
    } vec_t;

    function automatic vec_t mk(bit r, bit ls, bit ft, int h, int v, bit [3:0] en,
                                bit [3:0] ecap, int ecnt, bit elc, bit epl);
        vec_t t;
        t.r = r; t.ls = ls; t.ft = ft; t.h = h; t.v = v; t.en = en;
        t.ecap = ecap; t.ecnt = ecnt; t.elc = elc; t.epl = epl;
        return t;
    endfunction

    vec_t tbl[16];

    initial begin
        for (int z = 0; z < 4; z++) begin
            zone_hStart[z*12 +: 12] = 12'(zh[z]);
            zone_vStart[z*12 +: 12] = 12'(zv[z]);
            zone_width[z*12 +: 12]  = 12'(zw[z]);
            zone_height[z*12 +: 12] = 12'(zt[z]);
        end
        drive(1, 0, 0, 0, 0, 4'b0);

        // Basic dwell on zone0, edge exclusion, dwell break and hold without ticks.
        tbl[0]  = mk(1, 0, 0, 108, 55, 4'b0001, 4'b0000, 0, 0, 0); // reset
        tbl[1]  = mk(0, 0, 1, 108, 55, 4'b0001, 4'b0000, 0, 0, 0); // tick in IDLE ignored
        tbl[2]  = mk(0, 1, 0, 116, 55, 4'b0001, 4'b0000, 0, 0, 0); // arm
        tbl[3]  = mk(0, 0, 1, 116, 55, 4'b0001, 4'b0000, 0, 0, 0); // h = hStart+width: miss
        tbl[4]  = mk(0, 0, 1, 100, 50, 4'b0001, 4'b0000, 0, 0, 0); // corner: hit 1
        tbl[5]  = mk(0, 0, 1, 108, 55, 4'b0001, 4'b0000, 0, 0, 0); // hit 2
        tbl[6]  = mk(0, 0, 1, 108, 55, 4'b0001, 4'b0000, 0, 0, 0); // hit 3
        tbl[7]  = mk(0, 0, 1, 116, 55, 4'b0001, 4'b0000, 0, 0, 0); // miss breaks dwell
        tbl[8]  = mk(0, 0, 0, 108, 55, 4'b0001, 4'b0000, 0, 0, 0); // no tick
        tbl[9]  = mk(0, 0, 1, 108, 55, 4'b0001, 4'b0000, 0, 0, 0);
        tbl[10] = mk(0, 0, 1, 108, 55, 4'b0001, 4'b0000, 0, 0, 0);
        tbl[11] = mk(0, 0, 1, 108, 55, 4'b0001, 4'b0000, 0, 0, 0);
        tbl[12] = mk(0, 0, 1, 108, 55, 4'b0001, 4'b0001, 1, 0, 0); // 4th consecutive hit
        tbl[13] = mk(0, 0, 0, 108, 55, 4'b0001, 4'b0001, 1, 1, 1); // complete entry
        tbl[14] = mk(0, 0, 0, 108, 55, 4'b0001, 4'b0001, 1, 1, 0); // pulse one cycle
        tbl[15] = mk(0, 0, 1, 108, 55, 4'b0001, 4'b0001, 1, 1, 0); // tick in COMPLETE ignored

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].r, tbl[i].ls, tbl[i].ft, tbl[i].h, tbl[i].v, tbl[i].en);
            cycle();
            chk($sformatf("vec%0d captured", i), 32'(cap0), 32'(tbl[i].ecap));
            chk($sformatf("vec%0d capture_count", i), 32'(cnt0), 32'(tbl[i].ecnt));
            chk($sformatf("vec%0d level_complete", i), 32'(lc0), 32'(tbl[i].elc));
            chk($sformatf("vec%0d complete_pulse", i), 32'(pl0), 32'(tbl[i].epl));
        end

        // Ordered mode: dwelling in zone1 first does not count.
        drive(0, 1, 0, 118, 60, 4'b0011); cycle();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 118, 60, 4'b0011); cycle(); end
        chk("ord zone1 first captured", 32'(cap1), 32'h0);
        chk("ord zone1 first current", 32'(cur1), 32'h0);
        for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 101, 51, 4'b0011); cycle(); end
        chk("ord zone0 captured", 32'(cap1), 32'h1);
        chk("ord zone0 current", 32'(cur1), 32'h1);
        for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 118, 60, 4'b0011); cycle(); end
        chk("ord zone1 three ticks", 32'(cap1), 32'h1);
        drive(0, 0, 1, 118, 60, 4'b0011); cycle();
        chk("ord zone1 fourth tick", 32'(cap1), 32'h3);
        drive(0, 0, 0, 118, 60, 4'b0011); cycle();
        chk("ord complete", 32'(lc1), 32'h1);

        // Simultaneous capture in the overlap of zones 0 and 1.
        drive(0, 1, 0, 108, 55, 4'b0011); cycle();
        for (int i = 0; i < 4; i++) begin drive(0, 0, 1, 108, 55, 4'b0011); cycle(); end
        chk("sim captured", 32'(cap0), 32'h3);
        chk("sim count", 32'(cnt0), 32'h2);
        chk("sim lc at T+1", 32'(lc0), 32'h0);
        drive(0, 0, 0, 108, 55, 4'b0011); cycle();
        chk("sim lc at T+2", 32'(lc0), 32'h1);
        chk("sim pulse at T+2", 32'(pl0), 32'h1);

        // Empty enable set completes on the first tick.
        drive(0, 1, 0, 108, 55, 4'b0000); cycle();
        drive(0, 0, 0, 108, 55, 4'b0000); cycle();
        chk("empty no tick", 32'(lc0), 32'h0);
        drive(0, 0, 1, 108, 55, 4'b0000); cycle();
        chk("empty tick", 32'(lc0), 32'h1);
        chk("empty pulse", 32'(pl0), 32'h1);

        // Reset mid-dwell, then level_start with a coincident tick.
        drive(0, 1, 0, 108, 55, 4'b0001); cycle();
        for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 108, 55, 4'b0001); cycle(); end
        drive(1, 1, 1, 108, 55, 4'b0001); cycle();
        chk("rst captured", 32'(cap0), 32'h0);
        chk("rst visible", 32'(vis0), 32'h0);
        chk("rst count", 32'(cnt0), 32'h0);
        chk("rst current", 32'(cur0), 32'h0);
        chk("rst lc", 32'(lc0), 32'h0);
        drive(0, 1, 1, 108, 55, 4'b0001); cycle();
        chk("restart visible", 32'(vis0), 32'h1);
        for (int i = 0; i < 3; i++) begin drive(0, 0, 1, 108, 55, 4'b0001); cycle(); end
        chk("restart tick ignored", 32'(cap0), 32'h0);
        drive(0, 0, 1, 108, 55, 4'b0001); cycle();
        chk("restart capture", 32'(cap0), 32'h1);

        // Randomized run against the model; positions sweep zone edges.
        begin
            int h, v, z;
            bit [3:0] en;
            h = 108; v = 55; en = 4'b0011;
            for (int c = 0; c < 600; c++) begin
                if ($urandom_range(0, 5) == 0) begin
                    z = int'($urandom_range(0, 3));
                    h = zh[z] + int'($urandom_range(0, 32'(zw[z] + 1))) - 1;
                    v = zv[z] + int'($urandom_range(0, 32'(zt[z] + 1))) - 1;
                end
                if ($urandom_range(0, 29) == 0) en = 4'($urandom_range(0, 15));
                drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) == 0),
                      1'($urandom_range(0, 1)), h, v, en);
                cycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
